// File: rtl/mem_block_responder.sv
// Fixed-latency block memory responder for the L1 cache's 128-bit block interface.
// One request in flight; read data and write commit happen at the single mem_ready pulse.
module mem_block_responder #(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic         mem_ready,
    output logic [127:0] mem_rdata,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count,
    output logic         protocol_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAST_BUSY = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t                  state, state_nx;
    logic [7:0]              cnt, cnt_nx;
    logic                    op_wr;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [127:0]            wdata_q;
    logic [127:0]            store [0:DEPTH-1];

    logic                    accept, abort, rd_op_nx;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    unused_addr;

    // Aliasing of high address bits is intentional.
    assign unused_addr = ^mem_addr[27:DEPTH_LOG2];

    assign accept    = (state == IDLE) && (mem_read || mem_write);
    assign abort     = (state == BUSY) && !(mem_read || mem_write);
    assign mem_ready = (state == RESPOND);

    // With LATENCY==1 the store is read in the acceptance cycle, before idx is latched.
    assign rd_idx   = accept ? mem_addr[DEPTH_LOG2-1:0] : idx;
    assign rd_op_nx = accept ? mem_read : !op_wr;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx = RESPOND;
                        cnt_nx   = 8'd0;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = 8'd1;
                    end
                end
            end
            BUSY: begin
                if (abort) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end else if (cnt == LAST_BUSY) begin
                    state_nx = RESPOND;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            RESPOND: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            op_wr        <= 1'b0;
            idx          <= '0;
            wdata_q      <= '0;
            mem_rdata    <= '0;
            rd_count     <= 16'd0;
            wr_count     <= 16'd0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                // read+write together is served as a read
                op_wr   <= mem_write && !mem_read;
                idx     <= mem_addr[DEPTH_LOG2-1:0];
                wdata_q <= mem_wdata;
            end
            mem_rdata <= (state_nx == RESPOND && rd_op_nx) ? store[rd_idx] : '0;
            if ((accept && mem_read && mem_write) || abort)
                protocol_err <= 1'b1;
            if (state == RESPOND) begin
                if (op_wr) begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

    // Store has no reset; a reset in the RESPOND cycle suppresses the commit.
    always_ff @(posedge clk) begin
        if (!proc_reset && state == RESPOND && op_wr)
            store[idx] <= wdata_q;
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: LATENCY=8 and LATENCY=1 instances checked against
// a simple array/counter model with directed and randomized request sequences.
module tb_mem_block_responder;
    logic         clk;
    logic         rst [2];
    logic         mr [2];
    logic         mw [2];
    logic [27:0]  ma [2];
    logic [127:0] mwd [2];
    logic         rdy [2];
    logic [127:0] rdt [2];
    logic [15:0]  rc [2];
    logic [15:0]  wc [2];
    logic         perr [2];

    int ncmp = 0;
    int nerr = 0;

    logic [127:0] mdl   [2][1024];
    bit           known [2][1024];
    int unsigned  rcnt [2];
    int unsigned  wcnt [2];
    bit           errm [2];

    mem_block_responder #(.LATENCY(8), .DEPTH_LOG2(10)) dut8 (
        .clk(clk), .proc_reset(rst[0]), .mem_read(mr[0]), .mem_write(mw[0]),
        .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_ready(rdy[0]), .mem_rdata(rdt[0]),
        .rd_count(rc[0]), .wr_count(wc[0]), .protocol_err(perr[0]));

    mem_block_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
        .clk(clk), .proc_reset(rst[1]), .mem_read(mr[1]), .mem_write(mw[1]),
        .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_ready(rdy[1]), .mem_rdata(rdt[1]),
        .rd_count(rc[1]), .wr_count(wc[1]), .protocol_err(perr[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input int d, input string tag);
        check($sformatf("%s d%0d rd_count", tag, d), rc[d], 128'(rcnt[d]));
        check($sformatf("%s d%0d wr_count", tag, d), wc[d], 128'(wcnt[d]));
        check($sformatf("%s d%0d protocol_err", tag, d), perr[d], errm[d]);
    endtask

    // op: 0 read, 1 write, 2 read+write. Inputs are driven at a negedge; exp_edges is the
    // number of posedges until mem_ready is seen. chain leaves the next request to the caller.
    task automatic xact(input int d, input int op, input logic [27:0] a, input logic [127:0] dat,
                        input bit chain, input int exp_edges);
        int lat, edges, acc, i;
        bit got;
        lat = (d == 0) ? 8 : 1;
        acc = exp_edges - lat + 1;
        i = int'(a[9:0]);
        mr[d] = (op != 1); mw[d] = (op != 0); ma[d] = a; mwd[d] = dat;
        edges = 0; got = 0;
        while (!got && edges < exp_edges + 4) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (rdy[d]) got = 1;
            else begin
                check($sformatf("d%0d rdata zero while waiting", d), rdt[d], 128'd0);
                if (edges == acc && lat > 1) begin
                    ma[d]  = 28'($urandom);
                    mwd[d] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        check($sformatf("d%0d ready latency", d), 128'(edges), 128'(exp_edges));
        if (got) begin
            if (op == 1) begin
                mdl[d][i] = dat; known[d][i] = 1;
                if (wcnt[d] < 65535) wcnt[d]++;
            end else begin
                if (known[d][i]) check($sformatf("d%0d rdata @%h", d, a), rdt[d], mdl[d][i]);
                if (rcnt[d] < 65535) rcnt[d]++;
                if (op == 2) errm[d] = 1;
            end
        end
        if (!chain) begin
            mr[d] = 0; mw[d] = 0;
            @(posedge clk); @(negedge clk);
            check($sformatf("d%0d ready after pulse", d), rdy[d], 1'b0);
            check($sformatf("d%0d rdata after pulse", d), rdt[d], 128'd0);
            check_status(d, "post");
        end
    endtask

    // Request dropped while BUSY with cnt==3 (three edges after the request is set).
    task automatic abort_seq(input int d, input int op, input logic [27:0] a, input logic [127:0] dat);
        mr[d] = (op != 1); mw[d] = (op != 0); ma[d] = a; mwd[d] = dat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mr[d] = 0; mw[d] = 0;
        errm[d] = 1;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("d%0d abort no ready", d), rdy[d], 1'b0);
        end
        check_status(d, "abort");
    endtask

    initial begin
        logic [127:0] a5, d25, d13, dn;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1; mr[d] = 0; mw[d] = 0; ma[d] = '0; mwd[d] = '0;
            rcnt[d] = 0; wcnt[d] = 0; errm[d] = 0;
            for (int k = 0; k < 1024; k++) known[d][k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 0; rst[1] = 0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset ready", d), rdy[d], 1'b0);
            check($sformatf("d%0d reset rdata", d), rdt[d], 128'd0);
            check_status(d, "reset");
        end

        // basic write then read, LATENCY=8
        a5 = {16{8'hA5}};
        xact(0, 1, 28'h5, a5, 0, 8);
        xact(0, 0, 28'h5, '0, 0, 8);

        // write-back then refill back to back: pulses LATENCY+1 apart
        d25 = {$urandom, $urandom, $urandom, $urandom};
        d13 = {$urandom, $urandom, $urandom, $urandom};
        xact(0, 1, 28'h25, d25, 0, 8);
        xact(0, 1, 28'h13, d13, 1, 8);
        xact(0, 0, 28'h13, '0, 1, 9);
        xact(0, 0, 28'h25, '0, 0, 9);

        // LATENCY=1: held read ready every 2nd cycle, aliasing 0x405 vs 0x005
        dn = {$urandom, $urandom, $urandom, $urandom};
        xact(1, 1, 28'h405, dn, 0, 1);
        xact(1, 0, 28'h005, '0, 1, 1);
        for (int k = 0; k < 3; k++) xact(1, 0, 28'h005, '0, 1, 2);
        xact(1, 0, 28'h805, '0, 0, 2);

        // read+write together served as read, error sticky; aborted ops change nothing
        xact(0, 2, 28'h5, 128'h1234, 0, 8);
        abort_seq(0, 0, 28'h5, '0);
        abort_seq(0, 1, 28'h5, 128'hDEAD_BEEF);
        xact(0, 0, 28'h5, '0, 0, 8);
        check("d0 protocol_err sticky", perr[0], 1'b1);

        // reset in the middle of a write
        mr[0] = 0; mw[0] = 1; ma[0] = 28'h13; mwd[0] = ~d13;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst[0] = 1; mw[0] = 0;
        @(posedge clk); @(negedge clk);
        rst[0] = 0;
        rcnt[0] = 0; wcnt[0] = 0; errm[0] = 0;
        check("d0 midreset ready", rdy[0], 1'b0);
        check("d0 midreset rdata", rdt[0], 128'd0);
        check_status(0, "midreset");
        xact(0, 0, 28'h13, '0, 0, 8);

        // randomized traffic, random chaining, aliased upper address bits
        for (int d = 0; d < 2; d++) begin
            bit prev, ch;
            int lat;
            lat = (d == 0) ? 8 : 1;
            prev = 0;
            for (int k = 0; k < 24; k++) begin
                ch = (k < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
                xact(d, int'($urandom_range(0, 1)), {18'($urandom), 6'd0, 4'($urandom)},
                     {$urandom, $urandom, $urandom, $urandom}, ch, prev ? lat + 1 : lat);
                prev = ch;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
